// File: rtl/imsic_msi_arb_pkg.sv
// Shared types for the IMSIC MSI arbiter: FSM state encoding, address stride and request record.
package imsic_msi_arb_pkg;

    localparam int FILE_STRIDE = 12;
    localparam int REQ_FIELD_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    // Fields are wider than any configured FILE_W/ID_W so range checks never truncate.
    typedef struct packed {
        logic [REQ_FIELD_W-1:0] file;
        logic [REQ_FIELD_W-1:0] id;
    } msi_req_t;

endpackage

// File: rtl/imsic_msi_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the pointer and wraps around.
module rr_arbiter #(
    parameter int NR_REQ = 4,
    parameter int IDX_W  = $clog2(NR_REQ)
) (
    input  logic [NR_REQ-1:0] valid,
    input  logic [IDX_W-1:0]  pointer,
    output logic [NR_REQ-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NR_REQ; k++) begin
            cand = IDX_W'((int'(pointer) + k) % NR_REQ);
            if (!grant_valid && valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imsic_msi_arbiter.sv
// Round-robin MSI arbiter feeding a single AXI-lite write master with IMSIC seteipnum writes.
// Optional busy watchdog enabled by defining IMSIC_MSI_ARB_TIMEOUT_EN.
module imsic_msi_arbiter
    import imsic_msi_arb_pkg::*;
#(
    parameter int NR_REQ         = 4,
    parameter int NR_SRC         = 30,
    parameter int NR_INTP_FILES  = 2,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter logic [AXI_ADDR_WIDTH-1:0] IMSIC_BASE = 'h2400_0000,
    parameter int TIMEOUT_CYC    = 1024,
    parameter int FILE_W         = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1,
    parameter int ID_W           = $clog2(NR_SRC),
    parameter int GRANT_W        = $clog2(NR_REQ)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NR_REQ-1:0]                i_req_valid,
    output logic [NR_REQ-1:0]                o_req_ready,
    input  logic [NR_REQ-1:0][FILE_W-1:0]    i_req_file,
    input  logic [NR_REQ-1:0][ID_W-1:0]      i_req_id,
    output logic                             o_wr_valid,
    output logic [AXI_ADDR_WIDTH-1:0]        o_wr_addr,
    output logic [AXI_DATA_WIDTH-1:0]        o_wr_data,
    input  logic                             i_wr_busy,
    output logic                             o_busy,
    output logic [GRANT_W-1:0]               o_grant_idx,
    output logic                             o_drop,
    output logic                             o_err_timeout,
    input  logic                             i_err_clr
);

    arb_state_e         state;
    logic [GRANT_W-1:0] pointer;
    logic               drop_q;
    logic [NR_REQ-1:0]  arb_grant;
    logic [GRANT_W-1:0] arb_idx;
    logic               arb_found;
    msi_req_t           sel_req;
    logic               req_bad;
    logic               wd_expire;

    rr_arbiter #(
        .NR_REQ (NR_REQ),
        .IDX_W  (GRANT_W)
    ) u_rr (
        .valid       (i_req_valid),
        .pointer     (pointer),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_found)
    );

    always_comb begin
        sel_req      = '0;
        sel_req.file = REQ_FIELD_W'(i_req_file[arb_idx]);
        sel_req.id   = REQ_FIELD_W'(i_req_id[arb_idx]);
        req_bad      = (sel_req.id == '0) || (int'(sel_req.id) >= NR_SRC) ||
                       (int'(sel_req.file) >= NR_INTP_FILES);
    end

    assign o_req_ready = (state == IDLE) ? arb_grant : '0;
    assign o_wr_valid  = (state == ISSUE) && !drop_q;
    assign o_drop      = (state == ISSUE) && drop_q;
    assign o_busy      = (state != IDLE);

    // A rejected request still passes through ISSUE so the drop pulse lands one cycle after accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            pointer     <= GRANT_W'(NR_REQ - 1);
            o_grant_idx <= '0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            drop_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        pointer     <= arb_idx;
                        o_grant_idx <= arb_idx;
                        drop_q      <= req_bad;
                        if (!req_bad) begin
                            o_wr_addr <= IMSIC_BASE +
                                         (AXI_ADDR_WIDTH'(sel_req.file) << FILE_STRIDE);
                            o_wr_data <= AXI_DATA_WIDTH'(sel_req.id);
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE:     state <= drop_q ? IDLE : WAIT_BUSY;
                WAIT_BUSY: begin
                    if (wd_expire)      state <= IDLE;
                    else if (i_wr_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (wd_expire || !i_wr_busy) state <= IDLE;
                end
                default:   state <= IDLE;
            endcase
        end
    end

`ifdef IMSIC_MSI_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] wd_cnt;
    logic            err_q;

    assign wd_expire     = ((state == WAIT_BUSY) || (state == WAIT_DONE)) &&
                           (wd_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign o_err_timeout = err_q;

    // Counter restarts every launch; a new expiry outranks a same-cycle clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ISSUE)
                wd_cnt <= '0;
            else if ((state == WAIT_BUSY) || (state == WAIT_DONE))
                wd_cnt <= wd_cnt + TO_W'(1);
            if (wd_expire)
                err_q <= 1'b1;
            else if (i_err_clr)
                err_q <= 1'b0;
        end
    end
`else
    logic unused_wd_cfg;

    assign wd_expire     = 1'b0;
    assign o_err_timeout = 1'b0;
    assign unused_wd_cfg = i_err_clr ^ (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_imsic_msi_arbiter.sv
// Directed self-checking bench for imsic_msi_arbiter; adapts the watchdog scenario to
// whether IMSIC_MSI_ARB_TIMEOUT_EN is defined.
module tb_imsic_msi_arbiter;

    localparam logic [63:0] BASE = 64'h2400_0000;
`ifdef IMSIC_MSI_ARB_TIMEOUT_EN
    localparam int TO_CYC    = 16;
    localparam int BUSY_HOLD = 10;
`else
    localparam int TO_CYC    = 1024;
    localparam int BUSY_HOLD = 20;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][1:0]  req_file;
    logic [3:0][4:0]  req_id;
    logic             wr_valid;
    logic [63:0]      wr_addr;
    logic [63:0]      wr_data;
    logic             wr_busy;
    logic             busy;
    logic [1:0]       grant_idx;
    logic             drop;
    logic             err_timeout;
    logic             err_clr;

    int checks = 0;
    int passes = 0;

    imsic_msi_arbiter #(
        .NR_REQ        (4),
        .NR_SRC        (30),
        .NR_INTP_FILES (3),
        .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(64),
        .IMSIC_BASE    (BASE),
        .TIMEOUT_CYC   (TO_CYC)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_file    (req_file),
        .i_req_id      (req_id),
        .o_wr_valid    (wr_valid),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .i_wr_busy     (wr_busy),
        .o_busy        (busy),
        .o_grant_idx   (grant_idx),
        .o_drop        (drop),
        .o_err_timeout (err_timeout),
        .i_err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst       = 1'b1;
        req_valid = '0;
        req_file  = '0;
        req_id    = '0;
        wr_busy   = 1'b0;
        err_clr   = 1'b0;
        repeat (2) step;
        rst = 1'b0;
    endtask

    // Called just after the launch cycle was sampled; plays the write master for hold cycles.
    task automatic finish_write(input int hold, input logic [63:0] exp_addr,
                                input logic [63:0] exp_data);
        step;
        checks++;
        if (wr_valid !== 1'b0) $display("[TB] FAIL launch_one_cycle: got %b expected 0", wr_valid);
        else passes++;
        wr_busy = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step;
            checks++;
            if (req_ready !== 4'b0000) $display("[TB] FAIL ready_while_busy: got %b expected 0000", req_ready);
            else passes++;
            checks++;
            if (wr_addr !== exp_addr || wr_data !== exp_data)
                $display("[TB] FAIL addr_data_hold: got %h/%h expected %h/%h", wr_addr, wr_data, exp_addr, exp_data);
            else passes++;
        end
        wr_busy = 1'b0;
        step;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL return_idle: got busy=%b expected 0", busy);
        else passes++;
    endtask

    task automatic test_reset;
        apply_reset;
        checks++;
        if ({busy, wr_valid, drop, err_timeout} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, wr_valid, drop, err_timeout});
        else passes++;
        checks++;
        if (wr_addr !== 64'h0 || wr_data !== 64'h0)
            $display("[TB] FAIL reset_addr_data: got %h/%h expected 0/0", wr_addr, wr_data);
        else passes++;
        checks++;
        if (grant_idx !== 2'd0 || req_ready !== 4'b0000)
            $display("[TB] FAIL reset_grant_ready: got %0d/%b expected 0/0000", grant_idx, req_ready);
        else passes++;
    endtask

    task automatic test_single_write;
        req_file[0]  = 2'd1;
        req_id[0]    = 5'd5;
        req_valid    = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) $display("[TB] FAIL t1_ready: got %b expected 0001", req_ready);
        else passes++;
        step;
        checks++;
        if (wr_valid !== 1'b1 || busy !== 1'b1 || grant_idx !== 2'd0)
            $display("[TB] FAIL t1_launch: got valid=%b busy=%b idx=%0d expected 1/1/0", wr_valid, busy, grant_idx);
        else passes++;
        checks++;
        if (wr_addr !== 64'h2400_1000 || wr_data !== 64'd5)
            $display("[TB] FAIL t1_addr_data: got %h/%h expected 24001000/5", wr_addr, wr_data);
        else passes++;
        req_valid = '0;
        finish_write(2, 64'h2400_1000, 64'd5);
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_ready;
        int g;
        apply_reset;
        for (int i = 0; i < 4; i++) begin
            req_file[i] = 2'd0;
            req_id[i]   = 5'(i + 1);
        end
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            g = n % 4;
            exp_ready = 4'b0001 << g;
            #1;
            checks++;
            if (req_ready !== exp_ready) $display("[TB] FAIL rr_ready_%0d: got %b expected %b", n, req_ready, exp_ready);
            else passes++;
            step;
            checks++;
            if (wr_valid !== 1'b1 || grant_idx !== 2'(g) || wr_data !== 64'(g + 1) || wr_addr !== BASE)
                $display("[TB] FAIL rr_launch_%0d: got v=%b idx=%0d data=%h addr=%h expected 1/%0d/%0d/%h",
                         n, wr_valid, grant_idx, wr_data, wr_addr, g, g + 1, BASE);
            else passes++;
            finish_write(1, BASE, 64'(g + 1));
        end
        req_valid = '0;
    endtask

    task automatic test_drop;
        logic [1:0] vfile [4] = '{2'd0, 2'd0, 2'd3, 2'd2};
        logic [4:0] vid   [4] = '{5'd0, 5'd30, 5'd5, 5'd29};
        for (int v = 0; v < 3; v++) begin
            req_file[2] = vfile[v];
            req_id[2]   = vid[v];
            req_valid   = 4'b0100;
            #1;
            checks++;
            if (req_ready !== 4'b0100) $display("[TB] FAIL drop_ready_%0d: got %b expected 0100", v, req_ready);
            else passes++;
            step;
            checks++;
            if (drop !== 1'b1 || wr_valid !== 1'b0 || grant_idx !== 2'd2)
                $display("[TB] FAIL drop_pulse_%0d: got drop=%b v=%b idx=%0d expected 1/0/2", v, drop, wr_valid, grant_idx);
            else passes++;
            step;
            checks++;
            if (drop !== 1'b0 || busy !== 1'b0 || wr_valid !== 1'b0)
                $display("[TB] FAIL drop_end_%0d: got drop=%b busy=%b v=%b expected 0/0/0", v, drop, busy, wr_valid);
            else passes++;
        end
        req_file[2] = vfile[3];
        req_id[2]   = vid[3];
        #1;
        checks++;
        if (req_ready !== 4'b0100) $display("[TB] FAIL edge_ready: got %b expected 0100", req_ready);
        else passes++;
        step;
        checks++;
        if (wr_valid !== 1'b1 || drop !== 1'b0 || wr_addr !== 64'h2400_2000 || wr_data !== 64'd29)
            $display("[TB] FAIL edge_launch: got v=%b drop=%b addr=%h data=%h expected 1/0/24002000/1d",
                     wr_valid, drop, wr_addr, wr_data);
        else passes++;
        req_valid = '0;
        finish_write(1, 64'h2400_2000, 64'd29);
    endtask

    task automatic test_long_busy;
        req_file[1] = 2'd1;
        req_id[1]   = 5'd7;
        req_file[3] = 2'd0;
        req_id[3]   = 5'd9;
        req_valid   = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) $display("[TB] FAIL busy_ready: got %b expected 0010", req_ready);
        else passes++;
        step;
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 64'h2400_1000 || wr_data !== 64'd7)
            $display("[TB] FAIL busy_launch: got v=%b addr=%h data=%h expected 1/24001000/7", wr_valid, wr_addr, wr_data);
        else passes++;
        req_valid = 4'b1000;
        finish_write(BUSY_HOLD, 64'h2400_1000, 64'd7);
        checks++;
        if (req_ready !== 4'b1000) $display("[TB] FAIL busy_next_grant: got %b expected 1000", req_ready);
        else passes++;
        step;
        checks++;
        if (wr_valid !== 1'b1 || grant_idx !== 2'd3 || wr_data !== 64'd9)
            $display("[TB] FAIL busy_next_launch: got v=%b idx=%0d data=%h expected 1/3/9", wr_valid, grant_idx, wr_data);
        else passes++;
        req_valid = '0;
        finish_write(1, BASE, 64'd9);
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 4; i++) begin
            req_file[i] = 2'd0;
            req_id[i]   = 5'(i + 1);
        end
        req_file[2] = 2'd1;
        req_valid   = 4'b0100;
        step;
        req_valid = '0;
        step;
        wr_busy = 1'b1;
        step;
        checks++;
        if (busy !== 1'b1 || wr_valid !== 1'b0) $display("[TB] FAIL mid_wait_done: got busy=%b v=%b expected 1/0", busy, wr_valid);
        else passes++;
        rst = 1'b1;
        step;
        checks++;
        if (busy !== 1'b0 || wr_valid !== 1'b0 || grant_idx !== 2'd0 || wr_addr !== 64'h0 || wr_data !== 64'h0)
            $display("[TB] FAIL mid_reset_outputs: got busy=%b v=%b idx=%0d addr=%h data=%h expected all 0",
                     busy, wr_valid, grant_idx, wr_addr, wr_data);
        else passes++;
        rst       = 1'b0;
        wr_busy   = 1'b0;
        req_file[2] = 2'd0;
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) $display("[TB] FAIL mid_pointer_reset: got %b expected 0001", req_ready);
        else passes++;
        step;
        req_valid = '0;
        finish_write(1, BASE, 64'd1);
    endtask

    task automatic test_timeout;
        int first_k;
        first_k     = 0;
        req_file[0] = 2'd0;
        req_id[0]   = 5'd4;
        req_valid   = 4'b0001;
        step;
        req_valid = '0;
        checks++;
        if (wr_valid !== 1'b1) $display("[TB] FAIL to_launch: got %b expected 1", wr_valid);
        else passes++;
        step;
        wr_busy = 1'b1;
`ifdef IMSIC_MSI_ARB_TIMEOUT_EN
        for (int k = 1; k <= 40; k++) begin
            step;
            if (err_timeout === 1'b1 && first_k == 0) first_k = k;
        end
        checks++;
        if (first_k != 16) $display("[TB] FAIL to_cycle: got %0d expected 16", first_k);
        else passes++;
        checks++;
        if (busy !== 1'b0 || err_timeout !== 1'b1)
            $display("[TB] FAIL to_idle_sticky: got busy=%b err=%b expected 0/1", busy, err_timeout);
        else passes++;
        err_clr = 1'b1;
        step;
        err_clr = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) $display("[TB] FAIL to_clear: got %b expected 0", err_timeout);
        else passes++;
        wr_busy = 1'b0;
        step;
`else
        repeat (40) step;
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL to_disabled: got err=%b busy=%b expected 0/1", err_timeout, busy);
        else passes++;
        err_clr = 1'b1;
        wr_busy = 1'b0;
        step;
        err_clr = 1'b0;
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL to_disabled_end: got err=%b busy=%b expected 0/0", err_timeout, busy);
        else passes++;
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        test_reset;
        test_single_write;
        test_round_robin;
        test_drop;
        test_long_busy;
        test_mid_reset;
        test_timeout;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
